auc_encoder: RTL and testbench
==============================

AUC_ENCODER -- requirements
Module: auc_encoder

Interface
REQ-001 Parameter WIDTH, default 256: data word width in bits.
REQ-002 Parameter ADDR, default 5: RAM address width in bits.
REQ-003 The block SHALL have one clock, clk, input, 1 bit; all sequential logic is on its rising edge.
REQ-004 rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 enc_start, input, 1 bit: single-cycle pulse from the core; the current operation has completed.
REQ-006 enc_mode, input, 3 bits: operation code, sampled with enc_start. RAND=000, INVS=001, MMUL=101.
REQ-007 enc_radd, output, ADDR bits: RAM read address, registered.
REQ-008 enc_rdat, input, WIDTH bits: RAM read data, valid exactly 1 cycle after enc_radd changes.
REQ-009 auc_odat, output, WIDTH bits: result word to the host, registered.
REQ-010 auc_ovld, output, 1 bit: auc_odat holds a valid word.
REQ-011 auc_ordy, input, 1 bit: the host accepts the word this cycle.
REQ-012 auc_olast, output, 1 bit: the current valid word is the final word of the result.
REQ-013 enc_busy, output, 1 bit: a readout is in progress.
REQ-014 enc_done, output, 1 bit: single-cycle pulse; the readout has finished.

Function
REQ-015 Result word lists SHALL be, in send order:
- RAND: K_NUM (address 11), 1 word.
- INVS: K_INV (address 12), 1 word.
- MMUL: X_KG (address 15), then K_NUM (address 11), 2 words.
- Any other mode: 0 words.
REQ-016 The FSM SHALL have states IDLE, RD, WAIT, SEND and DONE.
REQ-017 IDLE transitions on enc_start:
- Supported mode: go to RD and latch the mode and word index 0.
- Unsupported mode: go to DONE.
REQ-018 RD SHALL drive enc_radd to the address of the current word index, then go to WAIT.
REQ-019 WAIT SHALL capture enc_rdat into auc_odat, set auc_ovld=1, set auc_olast=1 if the index is the final one, then go to SEND.
REQ-020 SEND SHALL hold auc_odat, auc_ovld and auc_olast stable until auc_ordy=1.
REQ-021 On a cycle with auc_ovld=1 and auc_ordy=1, a transfer occurs:
- auc_ovld and auc_olast clear next cycle.
- If this was the last word: go to DONE.
- Otherwise: increment the index and go to RD.
REQ-022 DONE SHALL assert enc_done for exactly one cycle, then go to IDLE.
REQ-023 Timing from enc_start in IDLE at cycle T:
- enc_radd valid at T+1.
- auc_ovld=1 at T+3.
- Each subsequent word appears 3 cycles after the previous transfer.
REQ-024 enc_busy SHALL be 1 in every state except IDLE.
REQ-025 enc_start while enc_busy=1 SHALL be ignored; the latched mode SHALL NOT change.
REQ-026 enc_radd SHALL equal BLNK (31) whenever the state is not RD, WAIT or SEND.
REQ-027 auc_odat SHALL retain its last value when auc_ovld=0.
REQ-028 auc_ordy asserted while auc_ovld=0 SHALL have no effect.
REQ-029 The word index SHALL be 1 bit wide and SHALL NOT wrap past the word count of the latched mode.

Reset
REQ-030 While rst=1, asynchronously:
- state=IDLE, enc_radd=31, auc_odat=0.
- auc_ovld=0, auc_olast=0, enc_busy=0, enc_done=0.
- Index=0, latched mode=000.
REQ-031 Reset asserted mid-readout SHALL abort the readout; no enc_done pulse is produced, and the next enc_start after release starts a fresh readout.

Verification
REQ-032 RAND readout: RAM[11]=0xA5, enc_start with mode 000 at T, auc_ordy=1 held -> enc_radd=11 at T+1; auc_odat=0xA5, auc_ovld=1 and auc_olast=1 at T+3; enc_done=1 at T+5.
REQ-033 MMUL readout with backpressure: RAM[15]=0x1234, RAM[11]=0x77, auc_ordy=0 for 4 cycles after the first auc_ovld -> auc_odat stays 0x1234 with auc_olast=0 until the transfer; then 0x77 with auc_olast=1; exactly 2 transfers; one enc_done pulse.
REQ-034 Unsupported mode 011 -> auc_ovld never asserts; enc_done=1 at T+2; enc_radd stays 31.
REQ-035 Second enc_start with mode 000 during an MMUL readout -> ignored; exactly 2 words (X_KG, K_NUM) are sent.
REQ-036 rst pulsed while in SEND -> outputs return to reset values immediately; no enc_done; a following INVS readout returns RAM[12] correctly.

Source files
------------

// File: rtl/auc_encoder_if.sv
// Core/RAM/host signal bundle for the AUC result encoder.
// master = encoder side, slave = core/RAM/host side.
interface auc_encoder_if #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned ADDR  = 5
);
  logic             enc_start;
  logic [2:0]       enc_mode;
  logic [ADDR-1:0]  enc_radd;
  logic [WIDTH-1:0] enc_rdat;
  logic [WIDTH-1:0] auc_odat;
  logic             auc_ovld;
  logic             auc_ordy;
  logic             auc_olast;
  logic             enc_busy;
  logic             enc_done;

  modport master (
    input  enc_start, enc_mode, enc_rdat, auc_ordy,
    output enc_radd, auc_odat, auc_ovld, auc_olast, enc_busy, enc_done
  );

  modport slave (
    output enc_start, enc_mode, enc_rdat, auc_ordy,
    input  enc_radd, auc_odat, auc_ovld, auc_olast, enc_busy, enc_done
  );
endinterface

// File: rtl/auc_encoder.sv
// AUC result encoder: after a core operation, reads the result words for that
// mode from RAM and streams them to the host over a valid/ready channel.
module auc_encoder #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned ADDR  = 5
) (
  input  logic           clk,
  input  logic           rst,
  auc_encoder_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    SEND,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    MODE_RAND = 3'b000,
    MODE_INVS = 3'b001,
    MODE_MMUL = 3'b101
  } mode_e;

  localparam logic [ADDR-1:0] A_KNUM = ADDR'(11);
  localparam logic [ADDR-1:0] A_KINV = ADDR'(12);
  localparam logic [ADDR-1:0] A_XKG  = ADDR'(15);
  localparam logic [ADDR-1:0] A_BLNK = ADDR'(31);

  state_e           state_q;
  mode_e            mode_q;
  logic             idx_q;
  logic [ADDR-1:0]  radd_q;
  logic [WIDTH-1:0] odat_q;
  logic             ovld_q;
  logic             olast_q;
  logic             busy_q;
  logic             done_q;

  function automatic logic mode_ok(input logic [2:0] m);
    return (m == MODE_RAND) || (m == MODE_INVS) || (m == MODE_MMUL);
  endfunction

  function automatic logic [ADDR-1:0] word_addr(input mode_e m, input logic idx);
    case (m)
      MODE_INVS: return A_KINV;
      MODE_MMUL: return idx ? A_KNUM : A_XKG;
      default:   return A_KNUM;
    endcase
  endfunction

  function automatic logic word_last(input mode_e m, input logic idx);
    return (m != MODE_MMUL) || idx;
  endfunction

  // The read address is loaded on the edge that enters RD, so RAM data is
  // already valid when WAIT samples it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_RAND;
      idx_q   <= 1'b0;
      radd_q  <= A_BLNK;
      odat_q  <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.enc_start) begin
            busy_q <= 1'b1;
            if (mode_ok(bus.enc_mode)) begin
              mode_q  <= mode_e'(bus.enc_mode);
              idx_q   <= 1'b0;
              radd_q  <= word_addr(mode_e'(bus.enc_mode), 1'b0);
              state_q <= RD;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RD: begin
          radd_q  <= word_addr(mode_q, idx_q);
          state_q <= WAIT;
        end
        WAIT: begin
          odat_q  <= bus.enc_rdat;
          ovld_q  <= 1'b1;
          olast_q <= word_last(mode_q, idx_q);
          state_q <= SEND;
        end
        SEND: begin
          if (bus.auc_ordy) begin
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
            if (olast_q) begin
              radd_q  <= A_BLNK;
              state_q <= DONE;
            end else begin
              idx_q   <= 1'b1;
              radd_q  <= word_addr(mode_q, 1'b1);
              state_q <= RD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          radd_q  <= A_BLNK;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          radd_q  <= A_BLNK;
        end
      endcase
    end
  end

  assign bus.enc_radd  = radd_q;
  assign bus.auc_odat  = odat_q;
  assign bus.auc_ovld  = ovld_q;
  assign bus.auc_olast = olast_q;
  assign bus.enc_busy  = busy_q;
  assign bus.enc_done  = done_q;

endmodule

// File: tb/tb_auc_encoder.sv
// Scoreboard bench for auc_encoder: directed timing cases plus randomized
// readouts checked against a mode -> word-list reference table.
module tb_auc_encoder;
  localparam int unsigned W = 256;
  localparam int unsigned A = 5;
  localparam logic [A-1:0] BLNK = 5'd31;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  auc_encoder_if #(.WIDTH(W), .ADDR(A)) bus ();

  auc_encoder #(.WIDTH(W), .ADDR(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] ram [32];
  always @(posedge clk) bus.enc_rdat <= ram[bus.enc_radd];

  word_t exp_q[$];
  int    checks    = 0;
  int    failures  = 0;
  int    exp_done  = 0;
  int    xfers     = 0;
  bit    rand_rdy  = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference: each supported mode returns a fixed list of named RAM words.
  task automatic expect_readout(input logic [2:0] mode);
    logic [W-1:0] words[$];
    case (mode)
      3'b000: words.push_back(ram[11]);
      3'b001: words.push_back(ram[12]);
      3'b101: begin words.push_back(ram[15]); words.push_back(ram[11]); end
      default: ;
    endcase
    foreach (words[i]) exp_q.push_back('{data: words[i], last: (i == words.size() - 1)});
    exp_done++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] mode);
    bus.enc_start = 1'b1;
    bus.enc_mode  = mode;
    tick();
    bus.enc_start = 1'b0;
    bus.enc_mode  = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!bus.enc_done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.enc_done) begin
      failures++;
      $display("FAIL done_timeout: got no enc_done expected pulse within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_radd"},  W'(bus.enc_radd), W'(BLNK));
    check({tag, "_odat"},  bus.auc_odat, '0);
    check({tag, "_ovld"},  W'(bus.auc_ovld), '0);
    check({tag, "_olast"}, W'(bus.auc_olast), '0);
    check({tag, "_busy"},  W'(bus.enc_busy), '0);
    check({tag, "_done"},  W'(bus.enc_done), '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.auc_ordy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops the scoreboard on every transfer and polices hold/retain rules.
  initial begin
    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic         pl = 1'b0;
    logic [W-1:0] pd = '0;
    word_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr && bus.auc_ovld) begin
        check("hold_data", bus.auc_odat, pd);
        check("hold_last", W'(bus.auc_olast), W'(pl));
      end
      if (pv && pr && !bus.auc_ovld) check("retain_data", bus.auc_odat, pd);
      if (!bus.enc_busy) check("idle_radd", W'(bus.enc_radd), W'(BLNK));
      if (bus.auc_ovld && bus.auc_ordy) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected no word", bus.auc_odat);
        end else begin
          e = exp_q.pop_front();
          check("word_data", bus.auc_odat, e.data);
          check("word_last", W'(bus.auc_olast), W'(e.last));
        end
      end
      if (bus.enc_done) begin
        checks++;
        if (exp_done == 0) begin
          failures++;
          $display("FAIL unexpected_done: got enc_done=1 expected 0");
        end else begin
          exp_done--;
        end
      end
      pv = bus.auc_ovld;
      pr = bus.auc_ordy;
      pd = bus.auc_odat;
      pl = bus.auc_olast;
    end
  end

  initial begin
    int x0;
    rst = 1'b1;
    bus.enc_start = 1'b0;
    bus.enc_mode  = 3'b000;
    bus.auc_ordy  = 1'b0;
    foreach (ram[i]) ram[i] = '0;
    #3;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // RAND readout with exact cycle timing.
    ram[11] = W'(8'hA5);
    bus.auc_ordy = 1'b1;
    expect_readout(3'b000);
    start_op(3'b000);
    check("rand_radd_T1", W'(bus.enc_radd), W'(11));
    check("rand_busy_T1", W'(bus.enc_busy), W'(1));
    tick();
    tick();
    check("rand_ovld_T3", W'(bus.auc_ovld), W'(1));
    check("rand_olast_T3", W'(bus.auc_olast), W'(1));
    check("rand_odat_T3", bus.auc_odat, W'(8'hA5));
    tick();
    check("rand_done_T4", W'(bus.enc_done), W'(0));
    tick();
    check("rand_done_T5", W'(bus.enc_done), W'(1));
    tick();

    // Unsupported mode: no words, done two cycles after the start.
    expect_readout(3'b011);
    start_op(3'b011);
    check("bad_radd_T1", W'(bus.enc_radd), W'(BLNK));
    check("bad_ovld_T1", W'(bus.auc_ovld), W'(0));
    tick();
    check("bad_done_T2", W'(bus.enc_done), W'(1));
    check("bad_radd_T2", W'(bus.enc_radd), W'(BLNK));
    tick();

    // MMUL with four cycles of backpressure on the first word.
    ram[15] = W'(16'h1234);
    ram[11] = W'(8'h77);
    bus.auc_ordy = 1'b0;
    x0 = xfers;
    expect_readout(3'b101);
    start_op(3'b101);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("bp_ovld", W'(bus.auc_ovld), W'(1));
      check("bp_odat", bus.auc_odat, W'(16'h1234));
      check("bp_olast", W'(bus.auc_olast), W'(0));
      tick();
    end
    bus.auc_ordy = 1'b1;
    wait_done(30);
    check("bp_xfers", W'(xfers - x0), W'(2));

    // A second start during an MMUL readout must be ignored.
    ram[15] = rand_word();
    ram[11] = rand_word();
    x0 = xfers;
    expect_readout(3'b101);
    start_op(3'b101);
    bus.enc_start = 1'b1;
    bus.enc_mode  = 3'b000;
    tick();
    bus.enc_start = 1'b0;
    wait_done(30);
    check("ignore_xfers", W'(xfers - x0), W'(2));

    // Reset while a word is held in SEND.
    bus.auc_ordy = 1'b0;
    expect_readout(3'b101);
    start_op(3'b101);
    tick();
    tick();
    check("abort_ovld_pre", W'(bus.auc_ovld), W'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    exp_done = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    ram[12] = rand_word();
    bus.auc_ordy = 1'b1;
    expect_readout(3'b001);
    start_op(3'b001);
    wait_done(30);

    // Randomized readouts with random host backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [2:0] m;
      ram[11] = rand_word();
      ram[12] = rand_word();
      ram[15] = rand_word();
      m = 3'($urandom_range(0, 7));
      expect_readout(m);
      start_op(m);
      wait_done(200);
    end
    rand_rdy = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    check("queue_empty", W'(exp_q.size()), '0);
    check("done_balance", W'(exp_done), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
